load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface for the 3-stage pipeline. It accepts one load or store per request from the execute/memory stage and performs byte-lane alignment and write strobes. It runs a valid/ready request plus response-valid handshake to the word-addressed data memory, then returns sign- or zero-extended load data. While a transaction is outstanding it stalls the pipeline and flags misaligned or illegal accesses without touching memory.

## Interface
- WIDTH, 32, data/address width; byte lanes = WIDTH/8 = 4
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- lsu_req  in  1  pipeline requests a memory op; held until lsu_done
- lsu_we  in  1  1 = store, 0 = load
- lsu_funct3  in  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned (loads only)
- lsu_addr  in  WIDTH  byte address
- lsu_wdata  in  WIDTH  store data, right-justified
- lsu_stall  out  1  freeze pipeline
- lsu_done  out  1  one-cycle completion pulse
- lsu_fault  out  1  one-cycle pulse with lsu_done on misaligned/illegal access
- lsu_rdata  out  WIDTH  extended load result
- mem_valid  out  1  request valid
- mem_ready  in  1  memory accepts request
- mem_we  out  1  request is write
- mem_addr  out  WIDTH  word-aligned address {lsu_addr[WIDTH-1:2],2'b00}
- mem_wstrb  out  4  byte write enables
- mem_wdata  out  WIDTH  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WIDTH  full read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE: on lsu_req, latch we/funct3/addr/wdata and check legality:
  - legal, aligned -> REQ
  - otherwise -> FAULT
  - Inputs are ignored in every other state.
- Illegal: store funct3 not in {000,001,010}; load funct3 in {011,110,111}.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- REQ: mem_valid=1; mem_addr, mem_we, mem_wstrb and mem_wdata are stable until mem_ready. On mem_ready: store -> DONE, load -> WAIT.
- WAIT: mem_valid=0. On mem_rvalid, capture the extracted data into lsu_rdata -> DONE. mem_rvalid is ignored outside WAIT.
- DONE: lsu_done=1 -> IDLE.
- FAULT: lsu_done=1, lsu_fault=1, no memory access, lsu_rdata unchanged -> IDLE.
- Store lanes, with o = addr[1:0]:
  - byte: wstrb = 0001<<o, wdata = {4{wdata[7:0]}}
  - half: wstrb = 0011<<o, wdata = {2{wdata[15:0]}}
  - word: wstrb = 1111, wdata = wdata
- Loads: mem_wstrb=0000. Lane = mem_rdata >> 8*o.
  - byte: extend bit 7 (signed) or zero (unsigned)
  - half: extend bit 15 (signed) or zero (unsigned)
  - word: as is
- lsu_stall = lsu_req in IDLE, 1 in REQ/WAIT, 0 in DONE/FAULT. The pipeline advances on the lsu_done cycle, and the next lsu_req is sampled in the following IDLE cycle.

## Timing
- Reset values, forced immediately on rst assertion:
  - state IDLE
  - mem_valid, mem_we, lsu_done, lsu_fault: 0
  - mem_wstrb 0000, mem_addr/mem_wdata/lsu_rdata: 0
  - lsu_stall 0 while rst is high
- Reset mid-transaction abandons the request. mem_valid drops asynchronously, and a late mem_rvalid is ignored.
- All mem_* and lsu_done/lsu_fault/lsu_rdata outputs are registered; only lsu_stall is combinational.
- Store latency with zero-wait memory:
  - cycle 0: lsu_req seen
  - cycle 1: mem_valid & mem_ready
  - cycle 2: lsu_done
  - 3 cycles total
- Load latency, minimum:
  - cycle 0: lsu_req seen
  - cycle 1: handshake
  - cycle 2: mem_rvalid
  - cycle 3: lsu_done with lsu_rdata valid
- Each cycle of mem_ready=0 or late mem_rvalid adds one cycle.
- Fault latency: lsu_done/lsu_fault in cycle 1.
- lsu_rdata holds its value until the next successful load.

## Test plan
- Store word: addr 0x10, wdata 0xDEADBEEF, ready on first cycle -> mem_addr 0x10, wstrb 1111, wdata 0xDEADBEEF; done at cycle 2; stall high cycles 0–1.
- Store byte: addr 0x13, wdata 0x000000A5 -> wstrb 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x10.
- Load extension: mem_rdata 0x80F1_7F82.
  - LB addr 0x0 -> 0xFFFFFF82
  - LBU addr 0x0 -> 0x00000082
  - LH addr 0x2 -> 0xFFFF80F1
  - LHU addr 0x2 -> 0x000080F1
  - LW -> 0x80F17F82
- Backpressure: mem_ready low 3 cycles, rvalid 2 cycles later -> mem_valid/mem_addr stable throughout; stall held; done at cycle 8.
- Faults: LW addr 0x6, SH addr 0x1, store funct3 100 -> mem_valid never asserts; done and fault pulse in cycle 1; lsu_rdata unchanged.
- Reset during WAIT: rst pulse, then mem_rvalid=1 -> no done pulse, lsu_rdata 0, next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: data-memory initiator for the 3-stage pipeline.
// Aligns byte lanes, drives write strobes and extends load data.
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_req,
  input  logic             lsu_we,
  input  logic [2:0]       lsu_funct3,
  input  logic [WIDTH-1:0] lsu_addr,
  input  logic [WIDTH-1:0] lsu_wdata,
  output logic             lsu_stall,
  output logic             lsu_done,
  output logic             lsu_fault,
  output logic [WIDTH-1:0] lsu_rdata,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    FAULT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       we_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  logic             illegal;
  logic             misaligned;
  logic             accept;
  logic [3:0]       st_strb;
  logic [WIDTH-1:0] st_data;
  logic [WIDTH-1:0] lane;
  logic [WIDTH-1:0] ld_data;

  assign accept = (state_q == IDLE) & lsu_req;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (lsu_we) begin
      illegal = lsu_funct3[2] | (lsu_funct3[1:0] == 2'b11);
    end else begin
      illegal = (lsu_funct3 == 3'b011) | (lsu_funct3[2:1] == 2'b11);
    end
    unique case (lsu_funct3[1:0])
      2'b01:   misaligned = lsu_addr[0];
      2'b10:   misaligned = |lsu_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    st_strb = 4'b1111;
    st_data = lsu_wdata;
    unique case (lsu_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << lsu_addr[1:0];
        st_data = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << lsu_addr[1:0];
        st_data = {2{lsu_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = lsu_wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extension.
  assign lane = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_data = lane;
    unique case (f3_q)
      3'b000:  ld_data = {{(WIDTH-8){lane[7]}}, lane[7:0]};
      3'b100:  ld_data = {{(WIDTH-8){1'b0}}, lane[7:0]};
      3'b001:  ld_data = {{(WIDTH-16){lane[15]}}, lane[15:0]};
      3'b101:  ld_data = {{(WIDTH-16){1'b0}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (lsu_req) begin
          state_d = (illegal | misaligned) ? FAULT : REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
      lsu_done  <= 1'b0;
      lsu_fault <= 1'b0;
      lsu_rdata <= '0;
    end else begin
      mem_valid <= (state_d == REQ);
      lsu_done  <= (state_d == DONE) | (state_d == FAULT);
      lsu_fault <= (state_d == FAULT);
      if (accept) begin
        we_q  <= lsu_we;
        f3_q  <= lsu_funct3;
        off_q <= lsu_addr[1:0];
      end
      // Faulting requests never reach the memory-side registers.
      if (accept && (state_d == REQ)) begin
        mem_we    <= lsu_we;
        mem_addr  <= {lsu_addr[WIDTH-1:2], 2'b00};
        mem_wstrb <= lsu_we ? st_strb : 4'b0000;
        mem_wdata <= lsu_we ? st_data : '0;
      end
      if ((state_q == WAIT) && mem_rvalid) begin
        lsu_rdata <= ld_data;
      end
    end
  end

  always_comb begin
    lsu_stall = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE:    lsu_stall = lsu_req;
        REQ:     lsu_stall = 1'b1;
        WAIT:    lsu_stall = 1'b1;
        default: lsu_stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset corner
// sequences and randomized transactions against a reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_stall;
  logic        lsu_done;
  logic        lsu_fault;
  logic [31:0] lsu_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_fault(lsu_fault),
    .lsu_rdata(lsu_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = 32'h0;

  typedef struct {
    int          done_cyc;
    logic        flt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic        we;
    logic        stable;
    logic        vseen;
    logic        stall_ok;
    logic        pulse_ok;
  } obs_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] md;
    int          rdly;
    int          vdly;
    int          exp_done;
    logic        exp_flt;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request and plays the memory; ready is withheld for rdly
  // valid cycles, rvalid comes vdly cycles after the earliest slot.
  task automatic run_txn(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] md, input int rdly,
                         input int vdly, output obs_t o);
    int vcnt;
    int hs;
    vcnt = 0;
    hs = -1;
    o.done_cyc = -1; o.flt = 1'b0; o.addr = '0; o.wdata = '0;
    o.rdata = '0; o.wstrb = '0; o.we = 1'b0; o.stable = 1'b1;
    o.vseen = 1'b0; o.stall_ok = 1'b1; o.pulse_ok = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (lsu_done) o.pulse_ok = 1'b0;
        lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3;
        lsu_addr = a; lsu_wdata = wd;
      end else if (lsu_done) begin
        o.done_cyc = c; o.flt = lsu_fault; o.rdata = lsu_rdata;
        lsu_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        #1;
        if (lsu_stall) o.stall_ok = 1'b0;
        break;
      end else if (lsu_fault) begin
        o.pulse_ok = 1'b0;
      end
      if (mem_valid) begin
        if (!o.vseen) begin
          o.vseen = 1'b1; o.addr = mem_addr; o.wstrb = mem_wstrb;
          o.wdata = mem_wdata; o.we = mem_we;
        end else if (mem_addr !== o.addr || mem_wstrb !== o.wstrb ||
                     mem_wdata !== o.wdata || mem_we !== o.we) begin
          o.stable = 1'b0;
        end
        mem_ready = (vcnt >= rdly);
        vcnt++;
        if (mem_ready) hs = c;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (!we && hs >= 0 && c == hs + 1 + vdly) begin
        mem_rvalid = 1'b1; mem_rdata = md;
      end else if (mem_valid) begin
        mem_rvalid = 1'b1; mem_rdata = ~md;
      end else begin
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      #1;
      if (!lsu_stall) o.stall_ok = 1'b0;
    end
    lsu_req = 1'b0;
  endtask

  task automatic check_obs(input string tag, input logic we, input obs_t o,
                           input int exp_done, input logic exp_flt,
                           input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    chk({tag, "_done"}, o.done_cyc, exp_done);
    chk({tag, "_fault"}, {31'b0, o.flt}, {31'b0, exp_flt});
    chk({tag, "_rdata"}, o.rdata, exp_rdata);
    chk({tag, "_stall"}, {31'b0, o.stall_ok}, 32'd1);
    chk({tag, "_pulse"}, {31'b0, o.pulse_ok}, 32'd1);
    if (exp_flt) begin
      chk({tag, "_novalid"}, {31'b0, o.vseen}, 32'd0);
    end else begin
      chk({tag, "_addr"}, o.addr, exp_addr);
      chk({tag, "_wstrb"}, {28'b0, o.wstrb}, {28'b0, exp_strb});
      chk({tag, "_we"}, {31'b0, o.we}, {31'b0, we});
      chk({tag, "_stable"}, {31'b0, o.stable}, 32'd1);
      if (we) chk({tag, "_wdata"}, o.wdata, exp_wdata);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] md, output logic flt,
                                output logic [3:0] strb, output logic [31:0] wdat,
                                output logic [31:0] rval);
    int nb;
    int s;
    logic [31:0] mask;
    logic [31:0] v;
    nb = 1 << f3[1:0];
    flt = 1'b0;
    if (we && f3 > 3'd2) flt = 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) flt = 1'b1;
    if (f3[1:0] != 2'd3 && (a % nb) != 0) flt = 1'b1;
    s = ((1 << nb) - 1) << a[1:0];
    strb = we ? s[3:0] : 4'b0000;
    if (nb == 1) wdat = (wd & 32'hFF) * 32'h01010101;
    else if (nb == 2) wdat = (wd & 32'hFFFF) * 32'h00010001;
    else wdat = wd;
    v = md >> (8 * a[1:0]);
    mask = (nb >= 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v = v & mask;
    if (!f3[2] && nb < 4 && ((v >> (8 * nb - 1)) & 32'h1) != 0) v = v | ~mask;
    rval = v;
  endfunction

  vec_t vecs[$];
  obs_t o;
  logic        r_flt;
  logic [3:0]  r_strb;
  logic [31:0] r_wdat;
  logic [31:0] r_val;
  logic        done_seen;

  initial begin
    rst = 1'b1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010;
    lsu_addr = '0; lsu_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    vecs.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 2, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, "sw"});
    vecs.push_back('{1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 0, 0, 2, 1'b0, 32'h10, 4'h8, 32'hA5A5A5A5, 32'h0, "sb"});
    vecs.push_back('{1'b1, 3'b001, 32'h02, 32'h1234BEEF, 32'h0, 1, 0, 3, 1'b0, 32'h0, 4'hC, 32'hBEEFBEEF, 32'h0, "sh"});
    vecs.push_back('{1'b0, 3'b000, 32'h0, 32'h0, 32'h80F17F82, 0, 0, 3, 1'b0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF82, "lb"});
    vecs.push_back('{1'b0, 3'b100, 32'h0, 32'h0, 32'h80F17F82, 0, 0, 3, 1'b0, 32'h0, 4'h0, 32'h0, 32'h00000082, "lbu"});
    vecs.push_back('{1'b0, 3'b001, 32'h2, 32'h0, 32'h80F17F82, 0, 0, 3, 1'b0, 32'h0, 4'h0, 32'h0, 32'hFFFF80F1, "lh"});
    vecs.push_back('{1'b0, 3'b101, 32'h2, 32'h0, 32'h80F17F82, 0, 0, 3, 1'b0, 32'h0, 4'h0, 32'h0, 32'h000080F1, "lhu"});
    vecs.push_back('{1'b0, 3'b010, 32'h0, 32'h0, 32'h80F17F82, 0, 0, 3, 1'b0, 32'h0, 4'h0, 32'h0, 32'h80F17F82, "lw"});
    vecs.push_back('{1'b0, 3'b000, 32'h3, 32'h0, 32'h7F000000, 0, 1, 4, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000007F, "lb3"});
    vecs.push_back('{1'b0, 3'b010, 32'h24, 32'h0, 32'h12345678, 3, 2, 8, 1'b0, 32'h24, 4'h0, 32'h0, 32'h12345678, "bp"});
    vecs.push_back('{1'b0, 3'b010, 32'h6, 32'h0, 32'hFFFFFFFF, 0, 0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h12345678, "lw_mis"});
    vecs.push_back('{1'b1, 3'b001, 32'h1, 32'h5555, 32'h0, 0, 0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h12345678, "sh_mis"});
    vecs.push_back('{1'b1, 3'b100, 32'h0, 32'h77, 32'h0, 0, 0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h12345678, "st_ill"});
    vecs.push_back('{1'b0, 3'b011, 32'h8, 32'h0, 32'h1, 0, 0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h12345678, "ld_ill"});
    vecs.push_back('{1'b0, 3'b101, 32'h1, 32'h0, 32'h1, 0, 0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h12345678, "lh_mis"});

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_done", {31'b0, lsu_done}, 32'd0);
    chk("rst_fault", {31'b0, lsu_fault}, 32'd0);
    chk("rst_stall", {31'b0, lsu_stall}, 32'd0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    lsu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i].we, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].md,
              vecs[i].rdly, vecs[i].vdly, o);
      check_obs(vecs[i].name, vecs[i].we, o, vecs[i].exp_done, vecs[i].exp_flt,
                vecs[i].exp_addr, vecs[i].exp_strb, vecs[i].exp_wdata,
                vecs[i].exp_rdata);
    end

    // Reset while the request is on the bus.
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h40;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rq_valid", {31'b0, mem_valid}, 32'd1);
    #2 rst = 1'b1;
    lsu_req = 1'b0;
    #1;
    chk("rq_rst_valid", {31'b0, mem_valid}, 32'd0);
    chk("rq_rst_stall", {31'b0, lsu_stall}, 32'd0);
    chk("rq_rst_rdata", lsu_rdata, 32'd0);
    model_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;

    // Reset while waiting for read data, then a late rvalid.
    @(negedge clk);
    lsu_req = 1'b1; lsu_addr = 32'h44; mem_ready = 1'b1;
    @(negedge clk);
    chk("wt_valid", {31'b0, mem_valid}, 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("wt_stall", {31'b0, lsu_stall}, 32'd1);
    rst = 1'b1;
    lsu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (lsu_done) done_seen = 1'b1;
    end
    chk("wt_no_done", {31'b0, done_seen}, 32'd0);
    chk("wt_rdata", lsu_rdata, 32'd0);
    run_txn(1'b0, 3'b010, 32'h44, 32'h0, 32'h0BADF00D, 0, 0, o);
    check_obs("wt_next", 1'b0, o, 3, 1'b0, 32'h44, 4'h0, 32'h0, 32'h0BADF00D);
    model_rdata = 32'h0BADF00D;

    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] md;
      int          rdly;
      int          vdly;
      int          ed;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; wd = $urandom; md = $urandom;
      rdly = $urandom_range(0, 3);
      vdly = $urandom_range(0, 3);
      model(we, f3, a, wd, md, r_flt, r_strb, r_wdat, r_val);
      if (!r_flt && !we) model_rdata = r_val;
      ed = r_flt ? 1 : (we ? 2 + rdly : 3 + rdly + vdly);
      run_txn(we, f3, a, wd, md, rdly, vdly, o);
      check_obs("rnd", we, o, ed, r_flt, a & 32'hFFFFFFFC, r_strb, r_wdat, model_rdata);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
